cf_apb_initiator: RTL

APB initiator that converts a simple valid/ready command stream into APB3 transfers (PADDR/PSEL/PENABLE/PWRITE/PWDATA, sampling PRDATA/PREADY) and returns one response per command. It is the requester side of the APB interface exposed by the CF peripheral wrappers. It is used as the bus driver in the peripheral verification benches and as a CPU-side bridge in integration tops. It issues one transfer at a time, with no outstanding-transaction overlap.

---
 rtl/cf_apb_init_pkg.sv | 19 +
 rtl/cf_apb_initiator_if.sv | 36 +++
 rtl/cf_apb_wdog.sv | 27 ++
 rtl/cf_apb_initiator.sv | 106 ++++++++++
 4 files changed

// File: rtl/cf_apb_init_pkg.sv
// Shared types for the CF APB initiator: FSM state encoding and the
// sizing helper for the optional ACCESS watchdog.
package cf_apb_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int TIMEOUT_DFLT = 16;

  // Width of a counter that must be able to hold the value TIMEOUT.
  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cf_apb_initiator_if.sv
// Command/response stream plus APB3 bus seen by the CF APB initiator.
// Handshakes: a beat transfers on a rising clock edge where valid and ready
// are both high; the producer holds valid and its payload until that edge.
interface cf_apb_initiator_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface

// File: rtl/cf_apb_wdog.sv
// ACCESS-phase watchdog: counter cleared by load, advanced by en, with an
// expiry flag raised during the LIMIT-th counted cycle.
module cf_apb_wdog #(
  parameter int W     = 5,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;

  // Count holds k-1 during the k-th enabled cycle; it parks once expired.
  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cf_apb_initiator.sv
// APB3 initiator: one command in, one APB transfer out, one response back.
// Define CF_APB_TIMEOUT_EN to abort ACCESS phases that outlast TIMEOUT cycles.
module cf_apb_initiator
  import cf_apb_init_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  cf_apb_initiator_if.master  bus,
  output logic [1:0]          fsm_state
);
  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_SETUP  = 2'(ST_SETUP);
  localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);
  localparam logic [1:0] S_RESP   = 2'(ST_RESP);

  logic [1:0]    state;
  logic [AW-1:0] paddr_q;
  logic          pwrite_q;
  logic [DW-1:0] pwdata_q;
  logic [DW-1:0] rdata_q;

  // Bus controls decode straight from the state register, so an async
  // reset drops PSEL/PENABLE immediately.
  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.PSEL      = (state == S_SETUP) || (state == S_ACCESS);
  assign bus.PENABLE   = (state == S_ACCESS);
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign fsm_state     = state;

`ifdef CF_APB_TIMEOUT_EN
  localparam int CW = tmo_cnt_w(TIMEOUT);

  logic tmo_hit;
  logic err_q;

  cf_apb_wdog #(.W(CW), .LIMIT(TIMEOUT)) u_wdog (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .load    (state == S_SETUP),
    .en      (state == S_ACCESS),
    .expired (tmo_hit)
  );

  // PREADY on the expiry cycle still counts as a normal completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_q <= 1'b0;
    end else if (state == S_ACCESS && (bus.PREADY || tmo_hit)) begin
      err_q <= !bus.PREADY;
    end
  end

  assign bus.rsp_err = err_q;
`else
  // TIMEOUT only matters when the watchdog is compiled in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign bus.rsp_err    = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            pwdata_q <= bus.req_wdata;
            state    <= S_SETUP;
          end
        end
        S_SETUP: state <= S_ACCESS;
        S_ACCESS: begin
          if (bus.PREADY) begin
            rdata_q <= pwrite_q ? '0 : bus.PRDATA;
            state   <= S_RESP;
          end
`ifdef CF_APB_TIMEOUT_EN
          else if (tmo_hit) begin
            rdata_q <= '0;
            state   <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
